// File: rtl/snake_body_occupancy_pkg.sv
// Shared grid constants, coordinate type and FSM encoding
// for the snake body occupancy block.
package snake_pkg;

    localparam int GRID_W = 40;
    localparam int GRID_H = 30;
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } coord_t;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_SCAN = 2'd2
    } state_e;

endpackage

// File: rtl/snake_body_occupancy_if.sv
// Occupancy-check handshake: the food placer is the master,
// the body store is the slave that answers.
interface snake_body_occupancy_if;

    logic                     q_valid_i;
    logic [snake_pkg::XW-1:0] q_x_i;
    logic [snake_pkg::YW-1:0] q_y_i;
    logic                     q_ready_o;
    logic                     occ_valid_o;
    logic                     occ_o;

    modport master (
        output q_valid_i,
        output q_x_i,
        output q_y_i,
        input  q_ready_o,
        input  occ_valid_o,
        input  occ_o
    );

    modport slave (
        input  q_valid_i,
        input  q_x_i,
        input  q_y_i,
        output q_ready_o,
        output occ_valid_o,
        output occ_o
    );

endinterface

// File: rtl/snake_body_occupancy_ram.sv
// Body ring storage: register array, one sync write port
// and one combinational read port.
module body_ring_ram
    import snake_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  coord_t        wdata_i,
    input  logic [AW-1:0] raddr_i,
    output coord_t        rdata_o
);

    coord_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/snake_body_occupancy.sv
// Snake body ring buffer (head first) with a serial,
// early-exit occupancy query engine.
module snake_body_occupancy
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = 64,
    parameter int INIT_LEN = 3,
    parameter int INIT_X   = 20,
    parameter int INIT_Y   = 15,
    parameter int LW       = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          move_valid_i,
    input  logic [XW-1:0] move_x_i,
    input  logic [YW-1:0] move_y_i,
    input  logic          grow_i,
    snake_body_occupancy_if.slave q_if,
    output logic [LW:0]   len_o,
    output logic          full_o,
    output logic          busy_o
);

    state_e        state_q;
    logic [LW-1:0] head_q;
    logic [LW:0]   len_q;
    logic [LW-1:0] init_cnt_q;
    logic [LW-1:0] idx_q;
    coord_t        qry_q;
    logic          occ_q;
    logic          occ_valid_q;

    logic          we;
    logic [LW-1:0] waddr;
    coord_t        wdata;
    logic [LW-1:0] raddr;
    coord_t        rdata;
    logic          move_en;
    logic          full;
    logic          hit;
    logic          last;

    assign full    = (len_q == (LW+1)'(MAX_LEN));
    assign move_en = move_valid_i && (state_q != ST_INIT);
    assign raddr   = head_q - idx_q;
    assign hit     = (rdata == qry_q);
    assign last    = ({1'b0, idx_q} == (len_q - 1'b1));

    // INIT lays the body out backwards from the head slot.
    always_comb begin
        we    = 1'b0;
        waddr = head_q + 1'b1;
        wdata = '{x: move_x_i, y: move_y_i};
        if (state_q == ST_INIT) begin
            we      = 1'b1;
            waddr   = LW'(0) - init_cnt_q;
            wdata.x = XW'(INIT_X) - XW'(init_cnt_q);
            wdata.y = YW'(INIT_Y);
        end else if (move_en) begin
            we = 1'b1;
        end
    end

    body_ring_ram #(
        .DEPTH (MAX_LEN),
        .AW    (LW)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            head_q      <= '0;
            len_q       <= '0;
            init_cnt_q  <= '0;
            idx_q       <= '0;
            qry_q       <= '0;
            occ_q       <= 1'b0;
            occ_valid_q <= 1'b0;
        end else begin
            occ_valid_q <= 1'b0;
            if (move_en) begin
                head_q <= head_q + 1'b1;
                if (grow_i && !full) begin
                    len_q <= len_q + 1'b1;
                end
            end
            unique case (state_q)
                ST_INIT: begin
                    len_q      <= {1'b0, init_cnt_q} + 1'b1;
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == LW'(INIT_LEN - 1)) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (q_if.q_valid_i) begin
                        qry_q   <= '{x: q_if.q_x_i, y: q_if.q_y_i};
                        idx_q   <= '0;
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // A move invalidates progress; rescan the new body.
                    if (move_en) begin
                        idx_q <= '0;
                    end else if (hit) begin
                        occ_q       <= 1'b1;
                        occ_valid_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else if (last) begin
                        occ_q       <= 1'b0;
                        occ_valid_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign q_if.q_ready_o   = (state_q == ST_IDLE);
    assign q_if.occ_valid_o = occ_valid_q;
    assign q_if.occ_o       = occ_q;
    assign len_o            = len_q;
    assign full_o           = full;
    assign busy_o           = (state_q != ST_IDLE);

endmodule
